// File: rtl/fp_ops_pkg.sv
// Shared types and constants for the single-precision multiply scheduler.
// The request id width and the stage entry layouts are defined here.
package fp_ops_pkg;

  localparam int          NUM_REQ_DEFAULT = 4;
  localparam logic [31:0] FP_NAN          = 32'h7FC0_0000;
  localparam logic [31:0] FP_INF          = 32'h7F80_0000;
  localparam int          FP_BIAS         = 127;

  typedef logic [1:0] req_id_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    req_id_t     id;
  } s1_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    req_id_t     id;
  } s2_entry_t;

endpackage

// File: rtl/fp_mul32.sv
// Combinational IEEE-754 single multiplier: truncating, subnormals flushed to zero,
// overflow saturates to infinity, any NaN result is the canonical quiet NaN.
module fp_mul32
  import fp_ops_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic               sign;
  logic [7:0]         ea, eb;
  logic [22:0]        ma, mb;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0]        prod;
  logic               norm;
  logic [22:0]        mant;
  logic signed [9:0]  e_sum;
  logic               unused_low;

  assign sign   = a[31] ^ b[31];
  assign ea     = a[30:23];
  assign eb     = b[30:23];
  assign ma     = a[22:0];
  assign mb     = b[22:0];
  assign a_nan  = (ea == 8'hFF) && (ma != '0);
  assign b_nan  = (eb == 8'hFF) && (mb != '0);
  assign a_inf  = (ea == 8'hFF) && (ma == '0);
  assign b_inf  = (eb == 8'hFF) && (mb == '0);
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);

  assign prod       = 48'({1'b1, ma}) * 48'({1'b1, mb});
  assign norm       = prod[47];
  assign mant       = norm ? prod[46:24] : prod[45:23];
  assign unused_low = ^prod[22:0];

  // Unbiased sum can go negative (underflow) or past 254 (overflow), hence 10 signed bits.
  assign e_sum = $signed({2'b00, ea}) + $signed({2'b00, eb})
               - $signed(10'(FP_BIAS)) + $signed({9'd0, norm});

  always_comb begin
    y = {sign, 31'd0};
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      y = FP_NAN;
    end else if (a_inf || b_inf) begin
      y = {sign, FP_INF[30:0]};
    end else if (a_zero || b_zero) begin
      y = {sign, 31'd0};
    end else if (e_sum >= 10'sd255) begin
      y = {sign, FP_INF[30:0]};
    end else if (e_sum <= 10'sd0) begin
      y = {sign, 31'd0};
    end else begin
      y = {sign, e_sum[7:0], mant};
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: the search starts one past the last winner (ptr).
module rr_arbiter4
  import fp_ops_pkg::*;
(
  input  logic [3:0] req,
  input  req_id_t    ptr,
  output logic [3:0] grant,
  output req_id_t    grant_idx,
  output logic       grant_any
);

  req_id_t idx;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    grant_any = 1'b0;
    idx       = ptr;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mul_sched.sv
// Four requesters share one multiplier through a round-robin arbiter feeding a
// two-stage elastic pipeline (S1 operands, S2 product) with in-order responses.
module fp_mul_sched
  import fp_ops_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_data,
  output logic [1:0]             rsp_id,
  input  logic                   rsp_ready,
  output logic                   busy,
  output logic [CNT_W-1:0]       op_count
);

  req_id_t     ptr;
  s1_entry_t   s1;
  s2_entry_t   s2;
  logic [3:0]  grant;
  req_id_t     grant_idx;
  logic        grant_any;
  logic        s1_advance;
  logic        s1_free;
  logic        accept;
  logic [31:0] sel_a, sel_b;
  logic [31:0] product;

  rr_arbiter4 u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  fp_mul32 u_mul (
    .a (s1.a),
    .b (s1.b),
    .y (product)
  );

  assign s1_advance = s1.valid && (!s2.valid || rsp_ready);
  assign s1_free    = !s1.valid || s1_advance;
  // Gated by rst_n so nothing looks accepted while the pipeline is held in reset.
  assign req_ready  = rst_n ? (grant & {NUM_REQ{s1_free}}) : '0;
  assign accept     = grant_any && (|(req_valid & req_ready));

  assign sel_a = req_a[{grant_idx, 5'd0} +: 32];
  assign sel_b = req_b[{grant_idx, 5'd0} +: 32];

  assign rsp_valid = s2.valid;
  assign rsp_data  = s2.data;
  assign rsp_id    = s2.id;
  assign busy      = s1.valid || s2.valid;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 2'd3;
      s1       <= '0;
      s2       <= '0;
      op_count <= '0;
    end else begin
      if (accept) begin
        ptr      <= grant_idx;
        s1.valid <= 1'b1;
        s1.a     <= sel_a;
        s1.b     <= sel_b;
        s1.id    <= grant_idx;
      end else if (s1_advance) begin
        s1.valid <= 1'b0;
      end

      // A draining S2 is overwritten by the advancing S1 in the same edge.
      if (s1_advance) begin
        s2.valid <= 1'b1;
        s2.data  <= product;
        s2.id    <= s1.id;
      end else if (rsp_ready) begin
        s2.valid <= 1'b0;
      end

      if (s2.valid && rsp_ready) begin
        op_count <= op_count + 1'b1;
      end
    end
  end

endmodule
